// File: rtl/icache_refill_wr.sv
// Instruction-cache line refill writer.
// Accepts one refill request, then takes 2^OWTH memory beats starting at the
// critical word. Each beat is written into the data array at {line, offset},
// and the offset wraps within the line. After a bus error, the remaining beats
// of the line are still drained but are no longer written. The refill ends with
// a done/err pulse that lines up with the last write slot.
// Optional feature macro: ICACHE_REFILL_CRIT_FWD_EN (forwards the critical word).
module icache_refill_wr #(
    parameter int DWTH = 32,
    parameter int LWTH = 3,
    parameter int OWTH = 3
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 req_vld_i,
    output logic                 req_rdy_o,
    input  logic [LWTH-1:0]      req_line_i,
    input  logic [OWTH-1:0]      req_word_i,
    input  logic                 rsp_vld_i,
    output logic                 rsp_rdy_o,
    input  logic [DWTH-1:0]      rsp_data_i,
    input  logic                 rsp_err_i,
    output logic                 wen_o,
    output logic [LWTH+OWTH-1:0] waddr_o,
    output logic [DWTH-1:0]      wdata_o,
    output logic                 crit_vld_o,
    output logic [DWTH-1:0]      crit_data_o,
    output logic                 done_o,
    output logic                 err_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    logic [LWTH-1:0] r_line;
    logic [OWTH-1:0] r_offset;
    logic [OWTH-1:0] r_count;
    logic            r_err;

    logic            w_beat;
    logic            w_last;
    logic            w_err_now;

    // A beat counts only while filling; beats offered at any other time are ignored.
    assign w_beat    = (r_state == S_FILL) && rsp_vld_i;
    assign w_last    = (r_count == {OWTH{1'b1}});
    assign w_err_now = r_err | rsp_err_i;

    assign req_rdy_o = (r_state == S_IDLE);
    assign rsp_rdy_o = (r_state == S_FILL);

    // Refill sequencer, plus the registered write port and completion outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state  <= S_IDLE;
            r_line   <= '0;
            r_offset <= '0;
            r_count  <= '0;
            r_err    <= 1'b0;
            wen_o    <= 1'b0;
            waddr_o  <= '0;
            wdata_o  <= '0;
            done_o   <= 1'b0;
            err_o    <= 1'b0;
        end else begin
            // Pulses default low and are raised only in the cycle they apply.
            wen_o  <= 1'b0;
            done_o <= 1'b0;
            err_o  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (req_vld_i) begin
                        r_line   <= req_line_i;
                        r_offset <= req_word_i;
                        r_count  <= '0;
                        r_err    <= 1'b0;
                        r_state  <= S_FILL;
                    end
                end
                S_FILL: begin
                    if (w_beat) begin
                        // Once an error is seen, drop this write and every later one.
                        wen_o    <= ~w_err_now;
                        waddr_o  <= {r_line, r_offset};
                        wdata_o  <= rsp_data_i;
                        r_err    <= w_err_now;
                        r_offset <= r_offset + OWTH'(1);
                        r_count  <= r_count + OWTH'(1);
                        if (w_last) begin
                            done_o  <= 1'b1;
                            err_o   <= w_err_now;
                            r_state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef ICACHE_REFILL_CRIT_FWD_EN
    logic [DWTH-1:0] r_crit_data;
    logic            r_crit_vld;

    // Forward the first beat of the line to the fetch path, but only if it is error-free.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_crit_vld  <= 1'b0;
            r_crit_data <= '0;
        end else begin
            r_crit_vld <= 1'b0;
            if (w_beat && (r_count == '0) && !rsp_err_i) begin
                r_crit_vld  <= 1'b1;
                r_crit_data <= rsp_data_i;
            end
        end
    end

    assign crit_vld_o  = r_crit_vld;
    assign crit_data_o = r_crit_data;
`else
    assign crit_vld_o  = 1'b0;
    assign crit_data_o = '0;
`endif

endmodule

// File: tb/tb_icache_refill_wr.sv
// Directed testbench for icache_refill_wr at its default parameters.
// Inputs change just after the falling edge. Outputs are sampled at the next
// falling edge, which is half a cycle after the rising edge that registers them.
module tb_icache_refill_wr;

`ifdef ICACHE_REFILL_CRIT_FWD_EN
    localparam bit CRIT_EN = 1'b1;
`else
    localparam bit CRIT_EN = 1'b0;
`endif

    logic        clk_i;
    logic        rst_i;
    logic        req_vld_i;
    logic        req_rdy_o;
    logic [2:0]  req_line_i;
    logic [2:0]  req_word_i;
    logic        rsp_vld_i;
    logic        rsp_rdy_o;
    logic [31:0] rsp_data_i;
    logic        rsp_err_i;
    logic        wen_o;
    logic [5:0]  waddr_o;
    logic [31:0] wdata_o;
    logic        crit_vld_o;
    logic [31:0] crit_data_o;
    logic        done_o;
    logic        err_o;

    int n_vec = 0;
    int n_err = 0;

    icache_refill_wr #(.DWTH(32), .LWTH(3), .OWTH(3)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .req_vld_i   (req_vld_i),
        .req_rdy_o   (req_rdy_o),
        .req_line_i  (req_line_i),
        .req_word_i  (req_word_i),
        .rsp_vld_i   (rsp_vld_i),
        .rsp_rdy_o   (rsp_rdy_o),
        .rsp_data_i  (rsp_data_i),
        .rsp_err_i   (rsp_err_i),
        .wen_o       (wen_o),
        .waddr_o     (waddr_o),
        .wdata_o     (wdata_o),
        .crit_vld_o  (crit_vld_o),
        .crit_data_o (crit_data_o),
        .done_o      (done_o),
        .err_o       (err_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk_i);
    endtask

    // Every output must be in its reset / quiet value.
    task automatic chk_quiet(input string tag);
        chk1({tag, ".wen"}, wen_o, 1'b0);
        chk32({tag, ".waddr"}, 32'(waddr_o), 32'd0);
        chk32({tag, ".wdata"}, wdata_o, 32'd0);
        chk1({tag, ".crit_vld"}, crit_vld_o, 1'b0);
        chk32({tag, ".crit_data"}, crit_data_o, 32'd0);
        chk1({tag, ".done"}, done_o, 1'b0);
        chk1({tag, ".err"}, err_o, 1'b0);
        chk1({tag, ".req_rdy"}, req_rdy_o, 1'b1);
        chk1({tag, ".rsp_rdy"}, rsp_rdy_o, 1'b0);
    endtask

    task automatic do_req(input logic [2:0] line, input logic [2:0] word);
        chk1("req.rdy_before", req_rdy_o, 1'b1);
        req_vld_i  = 1'b1;
        req_line_i = line;
        req_word_i = word;
        step();
        req_vld_i = 1'b0;
        chk1("req.rdy_after", req_rdy_o, 1'b0);
        chk1("req.rsp_rdy", rsp_rdy_o, 1'b1);
        $display("req   line=%0d word=%0d", line, word);
    endtask

    // One accepted beat, followed by a check of the registered write slot.
    task automatic beat(input logic [31:0] d, input logic e, input logic xw, input int xa,
                        input logic xd, input logic xe, input logic xc);
        chk1("beat.rsp_rdy", rsp_rdy_o, 1'b1);
        rsp_vld_i  = 1'b1;
        rsp_data_i = d;
        rsp_err_i  = e;
        step();
        rsp_vld_i = 1'b0;
        rsp_err_i = 1'b0;
        chk1("beat.wen", wen_o, xw);
        if (xw) begin
            chk32("beat.waddr", 32'(waddr_o), 32'(xa));
            chk32("beat.wdata", wdata_o, d);
        end
        chk1("beat.done", done_o, xd);
        chk1("beat.err", err_o, xe);
        chk1("beat.crit_vld", crit_vld_o, xc);
        if (xc) chk32("beat.crit_data", crit_data_o, d);
        if (!CRIT_EN) chk32("beat.crit_tie0", crit_data_o, 32'd0);
        $display("beat  data=%h err=%b -> wen=%b waddr=%0d done=%b err_o=%b crit=%b",
                 d, e, wen_o, waddr_o, done_o, err_o, crit_vld_o);
    endtask

    // An idle cycle (no valid beat) while still filling: nothing may be written.
    task automatic gap();
        rsp_vld_i = 1'b0;
        step();
        chk1("gap.wen", wen_o, 1'b0);
        chk1("gap.done", done_o, 1'b0);
        chk1("gap.req_rdy", req_rdy_o, 1'b0);
        $display("gap   wen=%b req_rdy=%b", wen_o, req_rdy_o);
    endtask

    // The cycle after done: the FSM must have returned to IDLE.
    task automatic after_done();
        chk1("done.req_rdy_in_done", req_rdy_o, 1'b0);
        chk1("done.rsp_rdy_in_done", rsp_rdy_o, 1'b0);
        step();
        chk1("idle.wen", wen_o, 1'b0);
        chk1("idle.done", done_o, 1'b0);
        chk1("idle.err", err_o, 1'b0);
        chk1("idle.req_rdy", req_rdy_o, 1'b1);
        $display("idle  req_rdy=%b", req_rdy_o);
    endtask

    int a_wrap [8] = '{22, 23, 16, 17, 18, 19, 20, 21};
    int a_gap  [8] = '{59, 60, 61, 62, 63, 56, 57, 58};
    int n_gaps [8] = '{0, 2, 0, 1, 3, 0, 1, 2};
    int a_post [8] = '{25, 26, 27, 28, 29, 30, 31, 24};

    initial begin
        rst_i      = 1'b1;
        req_vld_i  = 1'b0;
        req_line_i = '0;
        req_word_i = '0;
        rsp_vld_i  = 1'b0;
        rsp_data_i = '0;
        rsp_err_i  = 1'b0;
        step();
        step();
        chk_quiet("reset");
        $display("reset applied");
        rst_i = 1'b0;
        step();

        // Line 5 from word 0, eight back-to-back beats.
        do_req(3'd5, 3'd0);
        for (int i = 0; i < 8; i++)
            beat(32'hD000_0000 + 32'(i), 1'b0, 1'b1, 40 + i, i == 7, 1'b0, CRIT_EN && i == 0);
        after_done();

        // Line 2 from word 6: the offset wraps inside the line.
        do_req(3'd2, 3'd6);
        for (int i = 0; i < 8; i++)
            beat(32'hA5A5_0000 + 32'(i), 1'b0, 1'b1, a_wrap[i], i == 7, 1'b0, CRIT_EN && i == 0);
        after_done();

        // Bus error on beat 3: only beats 0..2 are written, but all 8 are accepted.
        do_req(3'd1, 3'd0);
        for (int i = 0; i < 8; i++)
            beat(32'hE000_0000 + 32'(i), i == 3, i < 3, 8 + i, i == 7, i == 7, CRIT_EN && i == 0);
        after_done();

        // Beats offered while IDLE must be ignored.
        rsp_vld_i  = 1'b1;
        rsp_data_i = 32'hBAD0_BAD0;
        for (int i = 0; i < 2; i++) begin
            step();
            chk1("idle_beat.wen", wen_o, 1'b0);
            chk1("idle_beat.req_rdy", req_rdy_o, 1'b1);
            chk1("idle_beat.rsp_rdy", rsp_rdy_o, 1'b0);
            $display("idle beat ignored wen=%b", wen_o);
        end
        rsp_vld_i = 1'b0;

        // Line 7 from word 3, with gaps of various lengths between beats.
        do_req(3'd7, 3'd3);
        for (int i = 0; i < 8; i++) begin
            for (int g = 0; g < n_gaps[i]; g++) gap();
            beat(32'h6600_0000 + 32'(i), 1'b0, 1'b1, a_gap[i], i == 7, 1'b0, CRIT_EN && i == 0);
        end
        after_done();

        // Reset after beat 4: the line is abandoned and no done follows.
        do_req(3'd4, 3'd0);
        for (int i = 0; i < 5; i++)
            beat(32'h4400_0000 + 32'(i), 1'b0, 1'b1, 32 + i, 1'b0, 1'b0, CRIT_EN && i == 0);
        rst_i = 1'b1;
        #1;
        chk_quiet("midrst");
        $display("reset asserted mid-fill");
        step();
        rst_i      = 1'b0;
        rsp_vld_i  = 1'b1;
        rsp_data_i = 32'hDEAD_0000;
        for (int i = 0; i < 3; i++) begin
            step();
            chk1("postrst.wen", wen_o, 1'b0);
            chk1("postrst.done", done_o, 1'b0);
            chk1("postrst.req_rdy", req_rdy_o, 1'b1);
            $display("post-reset beat ignored wen=%b done=%b", wen_o, done_o);
        end
        rsp_vld_i = 1'b0;

        // After the reset, a new request refills cleanly.
        do_req(3'd3, 3'd1);
        for (int i = 0; i < 8; i++)
            beat(32'h3300_0000 + 32'(i), 1'b0, 1'b1, a_post[i], i == 7, 1'b0, CRIT_EN && i == 0);
        after_done();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/icache_refill_wr.md
ICACHE_REFILL_WR -- requirements
Module: icache_refill_wr

Interface
REQ-001 SHALL have parameter DWTH, default 32, array word width in bits.
REQ-002 SHALL have parameter LWTH, default 3, line-index width.
REQ-003 SHALL have parameter OWTH, default 3, word-offset width; beats per line = 2^OWTH.
REQ-004 SHALL have port clk_i  input  1  single clock, all logic on rising edge.
REQ-005 SHALL have port rst_i  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port req_vld_i  input  1  refill request valid.
REQ-007 SHALL have port req_rdy_o  output  1  refill request accepted.
REQ-008 SHALL have port req_line_i  input  LWTH  target line index.
REQ-009 SHALL have port req_word_i  input  OWTH  critical (first) word offset.
REQ-010 SHALL have port rsp_vld_i  input  1  memory beat valid.
REQ-011 SHALL have port rsp_rdy_o  output  1  memory beat accepted.
REQ-012 SHALL have port rsp_data_i  input  DWTH  beat data.
REQ-013 SHALL have port rsp_err_i  input  1  beat carries bus error.
REQ-014 SHALL have port wen_o  output  1  array write enable.
REQ-015 SHALL have port waddr_o  output  LWTH+OWTH  array write address {line, offset}.
REQ-016 SHALL have port wdata_o  output  DWTH  array write data.
REQ-017 SHALL have port crit_vld_o  output  1  critical word forward valid, one-cycle pulse.
REQ-018 SHALL have port crit_data_o  output  DWTH  critical word data.
REQ-019 SHALL have port done_o  output  1  refill complete, one-cycle pulse.
REQ-020 SHALL have port err_o  output  1  refill ended with error, qualified by done_o.

Function
REQ-021 SHALL implement FSM IDLE, FILL, DONE; req_rdy_o = (state==IDLE); rsp_rdy_o = (state==FILL).
REQ-022 SHALL, on req_vld_i&&req_rdy_o, latch line/offset, clear beat counter and error flag, go FILL next cycle.
REQ-023 SHALL ignore rsp_vld_i outside FILL (no write, no state change).
REQ-024 SHALL, on each accepted beat, register wen_o=1, waddr_o={line,offset}, wdata_o=rsp_data_i for exactly the next cycle.
REQ-025 SHALL increment offset modulo 2^OWTH per accepted beat (wrap 7->0 at default).
REQ-026 SHALL, once an error beat is accepted, set a sticky error flag and suppress wen_o for that and all later beats of the line while still accepting them.
REQ-027 SHALL go FILL->DONE on acceptance of beat 2^OWTH; DONE->IDLE unconditionally next cycle.
REQ-028 SHALL assert done_o for exactly the cycle the last beat's wen_o slot occupies; err_o = sticky flag in that cycle, else 0.
REQ-029 SHALL tolerate rsp_vld_i gaps of any length in FILL without writes or counter change.
REQ-030 SHALL hold wen_o, crit_vld_o, done_o, err_o at 0 whenever not pulsing.

Reset
REQ-031 SHALL on rst_i: state IDLE, counter 0, error flag 0, wen_o 0, waddr_o 0, wdata_o 0, crit_vld_o 0, crit_data_o 0, done_o 0, err_o 0.
REQ-032 SHALL, if reset asserts mid-FILL, abandon the line: no further writes, no done_o after release.

Configuration
REQ-033 SHALL, with ICACHE_REFILL_CRIT_FWD_EN defined, pulse crit_vld_o with crit_data_o=rsp_data_i in the cycle after the first beat is accepted, only if that beat has rsp_err_i=0.
REQ-034 SHALL, without ICACHE_REFILL_CRIT_FWD_EN, tie crit_vld_o and crit_data_o to 0; all else unchanged.

Verification
REQ-035 SHALL cover: line=5, word=0, 8 back-to-back beats D0..D7 -> waddr 40..47 in order, done_o with last write, err_o=0.
REQ-036 SHALL cover: line=2, word=6 -> waddr 22,23,16..21 (wrap), crit_vld_o with beat 0 data when macro defined, 0 otherwise.
REQ-037 SHALL cover: rsp_err_i on beat 3 -> writes for beats 0-2 only, all 8 beats accepted, done_o with err_o=1.
REQ-038 SHALL cover: random rsp_vld_i gaps plus beats while IDLE -> exactly 8 writes, req_rdy_o low until DONE->IDLE.
REQ-039 SHALL cover: rst_i pulse after beat 4 -> all outputs 0, no done_o, next request refills cleanly.
